coin_dispenser: RTL

COIN_DISPENSER -- requirements
Module: coin_dispenser

---
 rtl/coin_pkg.sv | 11 +
 rtl/inv_counter.sv | 21 ++
 rtl/coin_dispenser.sv | 123 ++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// coin_pkg: shared coin encodings, dispenser state type and coin selection rule
// Used by coin_dispenser and vending_fsm; no ports.
package coin_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, OFFER, GAP, DONE, FAULT} state_t;
    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_ONE  = 2'd1;
    localparam logic [1:0] COIN_TWO  = 2'd2;
    function automatic logic [1:0] pick_coin(input logic [3:0] rem, input logic [3:0] inv2);
        return (rem >= 4'd2 && inv2 != 4'd0) ? COIN_TWO : COIN_ONE;
    endfunction
endpackage

// File: rtl/inv_counter.sv
// inv_counter: 4-bit saturating up/down inventory counter
// Ports: clk, rst (sync, active-high, loads INIT), inc_i / dec_i (one step each,
// both together hold the count), cnt_o (current count).
module inv_counter #(
    parameter int INIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] cnt_o
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt_o <= 4'(INIT);
        else if (inc_i && !dec_i && cnt_o != 4'hf)
            cnt_o <= cnt_o + 4'd1;
        else if (dec_i && !inc_i && cnt_o != 4'h0)
            cnt_o <= cnt_o - 4'd1;
    end
endmodule

// File: rtl/coin_dispenser.sv
// coin_dispenser: pays out change in unit/double coins from a refillable inventory
// Ports: clk, rst (sync, active-high); req_valid/req_amount/req_ready request handshake;
// coin_out/coin_valid/coin_ack coin offer handshake; refill1/refill2 inventory top-up;
// done/short completion pulse, fault ack-timeout level; inv1/inv2 inventory counts.
module coin_dispenser
    import coin_pkg::*;
#(
    parameter int ACK_TIMEOUT = 8,
    parameter int INIT_INV    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [3:0] req_amount,
    output logic       req_ready,
    output logic [1:0] coin_out,
    output logic       coin_valid,
    input  logic       coin_ack,
    input  logic       refill1,
    input  logic       refill2,
    output logic       done,
    output logic       short,
    output logic       fault,
    output logic [3:0] inv1,
    output logic [3:0] inv2
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [3:0]      rem_q, rem_d;
    logic [TW-1:0]   to_q, to_d;
    logic [1:0]      coin_q, coin_d;
    logic            short_q, short_d;
    logic [3:0]      n2;
    logic [4:0]      need;
    logic            acked;

    assign acked = state_q == OFFER && coin_ack;
    // Greedy plan: as many double coins as stock allows, the rest in unit coins.
    assign n2    = inv2 < {1'b0, rem_q[3:1]} ? inv2 : {1'b0, rem_q[3:1]};
    assign need  = {1'b0, rem_q} - {n2, 1'b0};

    inv_counter #(.INIT(INIT_INV)) u_inv1 (
        .clk   (clk),
        .rst   (rst),
        .inc_i (refill1),
        .dec_i (acked && coin_q == COIN_ONE),
        .cnt_o (inv1)
    );

    inv_counter #(.INIT(INIT_INV)) u_inv2 (
        .clk   (clk),
        .rst   (rst),
        .inc_i (refill2),
        .dec_i (acked && coin_q == COIN_TWO),
        .cnt_o (inv2)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        to_d    = to_q;
        coin_d  = coin_q;
        short_d = short_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = CHECK;
                rem_d   = req_amount;
                short_d = 1'b0;
            end
            CHECK: begin
                short_d = rem_q != 4'd0 && need > {1'b0, inv1};
                state_d = (rem_q == 4'd0 || short_d) ? DONE : OFFER;
                to_d    = '0;
                coin_d  = pick_coin(rem_q, inv2);
            end
            OFFER: if (coin_ack) begin
                rem_d   = rem_q - (coin_q == COIN_TWO ? 4'd2 : 4'd1);
                state_d = rem_d == 4'd0 ? DONE : GAP;
            end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
                state_d = FAULT;
            end else begin
                to_d = to_q + 1'b1;
            end
            // The coin is chosen once per offer so coin_out cannot move while valid.
            GAP: begin
                state_d = OFFER;
                to_d    = '0;
                coin_d  = pick_coin(rem_q, inv2);
            end
            DONE:    state_d = IDLE;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            to_q       <= '0;
            coin_q     <= COIN_NONE;
            short_q    <= 1'b0;
            req_ready  <= 1'b1;
            coin_valid <= 1'b0;
            coin_out   <= COIN_NONE;
            done       <= 1'b0;
            short      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            to_q       <= to_d;
            coin_q     <= coin_d;
            short_q    <= short_d;
            req_ready  <= state_d == IDLE;
            coin_valid <= state_d == OFFER;
            coin_out   <= state_d == OFFER ? coin_d : COIN_NONE;
            done       <= state_d == DONE;
            short      <= state_d == DONE && short_d;
            fault      <= state_d == FAULT;
        end
    end
endmodule
